// File: rtl/acl_spi_responder_pkg.sv
// Shared register map, opcodes and helpers for the ADXL362-style SPI responder
// and the accelerometer controller that drives it.
package acl_spi_responder_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);
  localparam int unsigned SAMPLE_W  = 12;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
  localparam logic [7:0] ADDR_PARTID     = 8'h02;
  localparam logic [7:0] ADDR_XDATA      = 8'h08;
  localparam logic [7:0] ADDR_YDATA      = 8'h09;
  localparam logic [7:0] ADDR_ZDATA      = 8'h0A;
  localparam logic [7:0] ADDR_STATUS     = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
  localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  localparam logic [7:0] DEVID_AD       = 8'hAD;
  localparam logic [7:0] DEVID_MST      = 8'h1D;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_IGNORE
  } spi_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] z;
  } accel_sample_t;

  // High byte of a 12-bit sample, sign-extended to 8 bits.
  function automatic logic [7:0] sample_hi_ext(input logic [SAMPLE_W-1:0] s);
    return {{4{s[SAMPLE_W-1]}}, s[SAMPLE_W-1:8]};
  endfunction

  // Addresses whose read consumes the current sample (clears DATA_READY).
  function automatic logic is_sample_addr(input logic [7:0] a);
    return ((a >= ADDR_XDATA) && (a <= ADDR_ZDATA)) ||
           ((a >= ADDR_XDATA_L) && (a <= ADDR_ZDATA_H));
  endfunction

endpackage

// File: rtl/acl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection
// taken from the last two synchronized samples.
module acl_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= (sync << 1) | SYNC_STAGES'(d);
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q      = sync[SYNC_STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 slave emulating the accelerometer register interface: read/write
// commands, auto-incrementing pointer, sample snapshot and DATA_READY flag.
module acl_spi_responder
  import acl_spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                ACL_SCLK,
  input  logic                ACL_CSN,
  input  logic                ACL_MOSI,
  output logic                ACL_MISO,
  input  logic [SAMPLE_W-1:0] i_accel_x,
  input  logic [SAMPLE_W-1:0] i_accel_y,
  input  logic [SAMPLE_W-1:0] i_accel_z,
  input  logic                i_sample_valid,
  output logic [7:0]          o_power_ctl,
  output logic [7:0]          o_filter_ctl,
  output logic                o_busy
);

  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic csn_q, csn_rise_c, csn_fall_c;
  logic unused_sclk_level;

  acl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .CLK    (CLK),
    .rst    (rst),
    .d      (ACL_SCLK),
    .q      (sclk_q),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  acl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .CLK    (CLK),
    .rst    (rst),
    .d      (ACL_CSN),
    .q      (csn_q),
    .rise_c (csn_rise_c),
    .fall_c (csn_fall_c)
  );

  assign unused_sclk_level = sclk_q;

  // MOSI only needs the level, delayed to line up with the SCLK edge pulse.
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(ACL_MOSI);
    end
  end

  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  spi_state_e             state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BYTE_W-1:0]      rx_sr;
  logic [BYTE_W-1:0]      tx_sr;
  logic [7:0]             ptr;
  logic                   cmd_rd;
  logic                   data_ready;
  logic                   fresh;
  logic                   read_sample;
  logic                   armed;
  logic [SYNC_STAGES:0]   settle;
  accel_sample_t          snap;

  logic [BYTE_W-1:0]      rx_byte_c;
  logic                   byte_done_c;
  logic [7:0]             ptr_next_c;
  logic [7:0]             rd_addr_c;
  logic [7:0]             rd_data_c;

  assign rx_byte_c   = {rx_sr[BYTE_W-2:0], mosi_q};
  assign byte_done_c = sclk_rise_c && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
  assign ptr_next_c  = ptr + 8'd1;

  // Byte to preload: the address just received, or the next pointer location.
  always_comb begin
    rd_addr_c = (state == ST_ADDR) ? rx_byte_c : ptr_next_c;
    rd_data_c = 8'h00;
    case (rd_addr_c)
      ADDR_DEVID_AD:   rd_data_c = DEVID_AD;
      ADDR_DEVID_MST:  rd_data_c = DEVID_MST;
      ADDR_PARTID:     rd_data_c = PARTID;
      ADDR_XDATA:      rd_data_c = snap.x[SAMPLE_W-1:4];
      ADDR_YDATA:      rd_data_c = snap.y[SAMPLE_W-1:4];
      ADDR_ZDATA:      rd_data_c = snap.z[SAMPLE_W-1:4];
      ADDR_STATUS:     rd_data_c = {7'd0, data_ready};
      ADDR_XDATA_L:    rd_data_c = snap.x[7:0];
      ADDR_XDATA_H:    rd_data_c = sample_hi_ext(snap.x);
      ADDR_YDATA_L:    rd_data_c = snap.y[7:0];
      ADDR_YDATA_H:    rd_data_c = sample_hi_ext(snap.y);
      ADDR_ZDATA_L:    rd_data_c = snap.z[7:0];
      ADDR_ZDATA_H:    rd_data_c = sample_hi_ext(snap.z);
      ADDR_FILTER_CTL: rd_data_c = o_filter_ctl;
      ADDR_POWER_CTL:  rd_data_c = o_power_ctl;
      default:         rd_data_c = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      ptr          <= '0;
      cmd_rd       <= 1'b0;
      data_ready   <= 1'b0;
      fresh        <= 1'b0;
      read_sample  <= 1'b0;
      armed        <= 1'b0;
      settle       <= '0;
      snap         <= '0;
      ACL_MISO     <= 1'b0;
      o_busy       <= 1'b0;
      o_power_ctl  <= POWER_CTL_RST;
      o_filter_ctl <= FILTER_CTL_RST;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      o_busy <= ~csn_q;

      // Only a genuine high->low CSN edge seen after reset may start decoding.
      if (settle[SYNC_STAGES] && csn_q) begin
        armed <= 1'b1;
      end

      if (i_sample_valid) begin
        data_ready <= 1'b1;
        fresh      <= 1'b1;
      end

      if (csn_rise_c) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        ACL_MISO <= 1'b0;
        // A sample that arrived after the snapshot was not read, so it keeps DATA_READY.
        if (read_sample) begin
          data_ready <= fresh | i_sample_valid;
        end
      end else if (csn_fall_c && armed) begin
        state       <= ST_CMD;
        bit_cnt     <= '0;
        rx_sr       <= '0;
        ACL_MISO    <= 1'b0;
        snap        <= '{x: i_accel_x, y: i_accel_y, z: i_accel_z};
        fresh       <= 1'b0;
        read_sample <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise_c) begin
          rx_sr   <= rx_byte_c;
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          if (byte_done_c) begin
            case (state)
              ST_CMD: begin
                if (rx_byte_c == CMD_READ) begin
                  cmd_rd <= 1'b1;
                  state  <= ST_ADDR;
                end else if (rx_byte_c == CMD_WRITE) begin
                  cmd_rd <= 1'b0;
                  state  <= ST_ADDR;
                end else begin
                  state <= ST_IGNORE;
                end
              end
              ST_ADDR: begin
                ptr <= rx_byte_c;
                if (cmd_rd) begin
                  state    <= ST_DATA_RD;
                  tx_sr    <= rd_data_c;
                  ACL_MISO <= rd_data_c[7];
                end else begin
                  state <= ST_DATA_WR;
                end
              end
              ST_DATA_RD: begin
                ptr      <= ptr_next_c;
                tx_sr    <= rd_data_c;
                ACL_MISO <= rd_data_c[7];
                if (is_sample_addr(ptr)) begin
                  read_sample <= 1'b1;
                end
              end
              ST_DATA_WR: begin
                if (ptr == ADDR_FILTER_CTL) begin
                  o_filter_ctl <= rx_byte_c;
                end else if (ptr == ADDR_POWER_CTL) begin
                  o_power_ctl <= rx_byte_c;
                end
                ptr <= ptr_next_c;
              end
              default: begin
              end
            endcase
          end
        end else if (sclk_fall_c && (state == ST_DATA_RD) && (bit_cnt != BIT_CNT_W'(0))) begin
          // The fall right after a preload keeps the MSB on the line.
          tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
          ACL_MISO <= tx_sr[BYTE_W-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Scoreboard bench: the SPI master pushes the expected MISO byte for every
// byte it clocks; a monitor assembles MISO on SCLK rises and compares.
module tb_acl_spi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] ax = '0, ay = '0, az = '0;
  logic        sv = 1'b0;
  logic [7:0]  power_ctl, filter_ctl;
  logic        busy;

  int total = 0;
  int bad = 0;
  int half = 5;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  acl_spi_responder #(.SYNC_STAGES(2), .PARTID(8'hF2)) dut (
    .CLK            (clk),
    .rst            (rst),
    .ACL_SCLK       (sclk),
    .ACL_CSN        (csn),
    .ACL_MOSI       (mosi),
    .ACL_MISO       (miso),
    .i_accel_x      (ax),
    .i_accel_y      (ay),
    .i_accel_z      (az),
    .i_sample_valid (sv),
    .o_power_ctl    (power_ctl),
    .o_filter_ctl   (filter_ctl),
    .o_busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[3'(7 - i)];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic [7:0] e);
    sb_q.push_back(e);
    spi_bits(b, 8);
  endtask

  task automatic cs_begin();
    csn = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (half) @(negedge clk);
    csn = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic read_txn(input logic [7:0] addr, input logic [7:0] e [6], input int n);
    cs_begin();
    xfer(8'h0B, 8'h00);
    xfer(addr, 8'h00);
    for (int i = 0; i < n; i++) xfer(8'h00, e[i]);
    cs_end();
  endtask

  task automatic write_txn(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1, input int n);
    cs_begin();
    xfer(8'h0A, 8'h00);
    xfer(addr, 8'h00);
    xfer(d0, 8'h00);
    if (n > 1) xfer(d1, 8'h00);
  endtask

  task automatic pulse_valid();
    sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
  endtask

  // Monitor: master-side view of MISO, sampled on every SCLK rise.
  initial begin : monitor
    int nbits;
    logic [7:0] cur;
    logic [7:0] exp_b;
    nbits = 0;
    cur = '0;
    forever begin
      @(posedge sclk or posedge csn or posedge rst);
      if (rst || csn) begin
        nbits = 0;
      end else begin
        cur = {cur[6:0], miso};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL miso_extra: got 0x%02h expected no byte", cur);
          end else begin
            exp_b = sb_q.pop_front();
            check("miso_byte", 32'(cur), 32'(exp_b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (5) @(negedge clk);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_power", 32'(power_ctl), 32'h00);
    check("rst_filter", 32'(filter_ctl), 32'h13);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // ID registers at 1 MHz SCLK
    half = 50;
    read_txn(8'h00, '{8'hAD, 8'h1D, 8'hF2, 8'h00, 8'h00, 8'h00}, 3);
    half = 5;

    // Sample readout and DATA_READY
    ax = 12'hF83; ay = 12'h07F; az = 12'h000;
    pulse_valid();
    read_txn(8'h08, '{8'hF8, 8'h07, 8'h00, 8'h01, 8'h00, 8'h00}, 4);
    read_txn(8'h0B, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    read_txn(8'h0E, '{8'h83, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00}, 6);

    // Register writes
    write_txn(8'h2D, 8'h02, 8'h00, 1);
    check("wr_power", 32'(power_ctl), 32'h02);
    cs_end();
    write_txn(8'h20, 8'h55, 8'h00, 1);
    cs_end();
    check("wr_other_power", 32'(power_ctl), 32'h02);
    check("wr_other_filter", 32'(filter_ctl), 32'h13);
    write_txn(8'h2C, 8'hA1, 8'h04, 2);
    cs_end();
    check("wr_burst_filter", 32'(filter_ctl), 32'hA1);
    check("wr_burst_power", 32'(power_ctl), 32'h04);
    read_txn(8'h2C, '{8'hA1, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    read_txn(8'hFF, '{8'h00, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00}, 2);

    // Partial write byte is discarded
    cs_begin();
    xfer(8'h0A, 8'h00);
    xfer(8'h2D, 8'h00);
    spi_bits(8'hFF, 5);
    cs_end();
    check("partial_power", 32'(power_ctl), 32'h04);

    // Mid-transaction sample does not disturb the snapshot but stays pending
    ax = 12'h123; ay = 12'h456; az = 12'h789;
    cs_begin();
    xfer(8'h0B, 8'h00);
    xfer(8'h0E, 8'h00);
    xfer(8'h00, 8'h23);
    xfer(8'h00, 8'h01);
    ax = 12'hFFF; ay = 12'hFFF; az = 12'hFFF;
    pulse_valid();
    xfer(8'h00, 8'h56);
    xfer(8'h00, 8'h04);
    xfer(8'h00, 8'h89);
    xfer(8'h00, 8'h07);
    cs_end();
    read_txn(8'h0B, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    // Unknown command is ignored, then a normal STATUS read
    cs_begin();
    xfer(8'h0D, 8'h00);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h00);
    cs_end();
    read_txn(8'h0B, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    // Reset in the middle of a read
    cs_begin();
    xfer(8'h0B, 8'h00);
    xfer(8'h00, 8'h00);
    spi_bits(8'h00, 2);
    repeat (half) @(negedge clk);
    check("pre_rst_miso", 32'(miso), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_power", 32'(power_ctl), 32'h00);
    check("midrst_filter", 32'(filter_ctl), 32'h13);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // CSN still low from before reset: no decoding until a fresh fall
    xfer(8'h0B, 8'h00);
    xfer(8'h00, 8'h00);
    xfer(8'h00, 8'h00);
    cs_end();
    read_txn(8'h00, '{8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    read_txn(8'h0B, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
ACL_SPI_RESPONDER -- requirements
Module: acl_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flip-flop stages on each SPI input before edge detection.
REQ-002 Parameter PARTID, default 8'hF2, value returned from register 0x02.
REQ-003 CLK  input  1  system clock, 100 MHz; sole clock of the block.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ACL_SCLK  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), at most CLK/8.
REQ-006 ACL_CSN  input  1  SPI chip select, active-low.
REQ-007 ACL_MOSI  input  1  SPI data from master, MSB first.
REQ-008 ACL_MISO  output  1  SPI data to master, MSB first.
REQ-009 i_accel_x, i_accel_y, i_accel_z  input  12 each  two's-complement sample values.
REQ-010 i_sample_valid  input  1  one-CLK strobe: new sample on i_accel_*.
REQ-011 o_power_ctl  output  8  current POWER_CTL register (0x2D).
REQ-012 o_filter_ctl  output  8  current FILTER_CTL register (0x2C).
REQ-013 o_busy  output  1  high while synchronized CSN is low.

Function
REQ-014 SCLK, CSN and MOSI SHALL each pass SYNC_STAGES flops; SCLK rise/fall and CSN fall/rise SHALL be detected from the last two synchronized samples.
REQ-015 FSM states: IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE; CSN fall -> CMD, bit counter cleared.
REQ-016 MOSI SHALL be sampled on each synchronized SCLK rise; byte complete on the 8th rise.
REQ-017 CMD byte 0x0B -> ADDR (read); 0x0A -> ADDR (write); any other value -> IGNORE.
REQ-018 After the address byte, read -> DATA_RD and write -> DATA_WR; address SHALL be held in an 8-bit pointer.
REQ-019 Pointer SHALL increment after each completed data byte and wrap 0xFF -> 0x00.
REQ-020 Read map:
- 0x00=0xAD; 0x01=0x1D; 0x02=PARTID.
- 0x08/0x09/0x0A = X/Y/Z bits[11:4].
- 0x0B = STATUS, bit0 DATA_READY, other bits 0.
- 0x0E/0x10/0x12 = X/Y/Z bits[7:0].
- 0x0F/0x11/0x13 = {4 copies of bit11, bits[11:8]}.
- 0x2C = FILTER_CTL; 0x2D = POWER_CTL; all other addresses 0x00.
REQ-021 On CSN fall, i_accel_x/y/z SHALL be snapshotted; all reads in that transaction return snapshot values.
REQ-022 A sample_valid arriving mid-transaction SHALL NOT alter the snapshot.
REQ-023 DATA_READY SHALL set on i_sample_valid and clear on CSN rise of any transaction that read any of 0x08-0x0A or 0x0E-0x13.
REQ-024 If set and clear coincide, set SHALL win.
REQ-025 Read data load:
- First read byte SHALL be loaded into the MISO shift register on the 8th SCLK rise of the address byte; ACL_MISO = its MSB within 1 CLK.
- Shift left on each synchronized SCLK fall.
- Next byte (incremented pointer) SHALL load on the 8th rise of each data byte.
REQ-026 ACL_MISO SHALL be 0 in IDLE, CMD, ADDR, DATA_WR, IGNORE.
REQ-027 In DATA_WR, a completed byte SHALL be committed on its 8th SCLK rise only if the pointer is 0x2C or 0x2D; other writes are discarded.
REQ-028 CSN rise in any state -> IDLE next CLK; a partial byte SHALL be discarded with no register write.
REQ-029 SCLK edges while CSN is high SHALL be ignored.
REQ-030 Worst-case CLK latency, SCLK pin edge -> MISO update: SYNC_STAGES+2.

Reset
REQ-031 On rst, all of the following SHALL apply on the next CLK edge, overriding any transaction in progress:
- FSM -> IDLE, counters and pointer 0;
- ACL_MISO=0, o_busy=0;
- POWER_CTL=0x00, FILTER_CTL=0x13;
- DATA_READY=0, snapshot registers 0;
- synchronizer flops: SCLK 0, CSN 1, MOSI 0.
REQ-032 After rst deasserts with CSN already low, the block SHALL wait for a CSN high->low transition before decoding.

Structure
REQ-033 Command opcodes, register addresses, ID constants and the FILTER_CTL/POWER_CTL reset values SHALL live in the shared package, also used by myAccelerometerCtrl.
REQ-034 Synchronizer plus edge detector SHALL be one sub-module, acl_sync_edge, instantiated for SCLK and CSN; MOSI uses its synchronizer output only.

Verification
REQ-035 Read of 0x00, 3 bytes, SCLK=1 MHz -> MISO returns 0xAD, 0x1D, 0xF2.
REQ-036 x=12'hF83, y=12'h07F, z=0, burst read from 0x0E, 6 bytes -> 0x83, 0xFF, 0x7F, 0x00, 0x00, 0x00.
REQ-037 Write 0x0A,0x2D,0x02 -> o_power_ctl=0x02 after 8th data rise; write 0x0A,0x20,0x55 -> no register changes.
REQ-038 Mid-operation cases:
- CSN raised after 5 data bits of a 0x2D write -> o_power_ctl unchanged.
- i_sample_valid during a burst -> snapshot unchanged.
- Afterwards, STATUS reads 0x01.
REQ-039 Command 0x0D then 16 SCLKs -> MISO constant 0; next 0x0B,0x0B transaction returns STATUS correctly.
REQ-040 rst asserted mid-read -> ACL_MISO=0 next CLK, o_busy=0, registers at reset values.
